// File: rtl/iiitb_cg_ctrl_pkg.sv
// Shared definitions for the clock-gate enable controller: FSM state
// encodings and default parameter values.
package iiitb_cg_pkg;

   localparam int unsigned DEF_WIDTH       = 2;
   localparam int unsigned DEF_IDLE_CYCLES = 4;
   localparam int unsigned DEF_LAT         = 2;
   localparam int unsigned DEF_CNT_W       = 16;

   // 2'd3 is unused; the controller recovers from it to ST_ACTIVE.
   typedef enum logic [1:0] {
      ST_ACTIVE = 2'd0,
      ST_GATED  = 2'd1,
      ST_WAKE   = 2'd2
   } cg_state_e;

endpackage

// File: rtl/iiitb_cg_ctrl_delay.sv
// Fixed-latency shift pipeline with synchronous reset. Used to align
// data with the clock-gate enable path; never stalled.
module iiitb_cg_delay
   import iiitb_cg_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned LAT   = DEF_LAT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_pipe [LAT];

   // Shift the word one stage per edge; reset clears every stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < LAT; i++) begin
            r_pipe[i] <= '0;
         end
      end else begin
         r_pipe[0] <= i_d;
         for (int unsigned i = 1; i < LAT; i++) begin
            r_pipe[i] <= r_pipe[i-1];
         end
      end
   end

   assign o_q = r_pipe[LAT-1];

endmodule

// File: rtl/iiitb_cg_ctrl.sv
// Activity-driven clock-gate enable controller. Keeps the ICG enable high
// while the monitored word changes, gates after IDLE_CYCLES quiet edges,
// and guarantees at least LAT enabled cycles after every wake so the
// delayed data reaches the gated registers.
module iiitb_cg_ctrl
   import iiitb_cg_pkg::*;
#(
   parameter int unsigned WIDTH       = DEF_WIDTH,
   parameter int unsigned IDLE_CYCLES = DEF_IDLE_CYCLES,
   parameter int unsigned LAT         = DEF_LAT,
   parameter int unsigned CNT_W       = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             force_on,
   output logic             cg_en,
   output logic [WIDTH-1:0] dout,
   output logic [CNT_W-1:0] gated_cnt,
   output logic [1:0]       state
);

   localparam int unsigned IDLE_W = $clog2(IDLE_CYCLES + 1);
   localparam int unsigned WAKE_W = $clog2(LAT + 1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
   localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(LAT - 1);

   cg_state_e          r_state;
   logic [WIDTH-1:0]   r_din_q;
   logic [IDLE_W-1:0]  r_idle_cnt;
   logic [WAKE_W-1:0]  r_wake_cnt;
   logic [CNT_W-1:0]   r_gated_cnt;

   cg_state_e          w_state_nxt;
   logic [IDLE_W-1:0]  w_idle_nxt;
   logic [WAKE_W-1:0]  w_wake_nxt;
   logic [CNT_W-1:0]   w_gated_nxt;
   logic               w_chg;
   logic               w_wake;

   assign w_chg  = (din != r_din_q);
   assign w_wake = w_chg | force_on;

   // State and counter registers; reset returns everything to idle-open.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_ACTIVE;
         r_din_q     <= '0;
         r_idle_cnt  <= '0;
         r_wake_cnt  <= '0;
         r_gated_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_din_q     <= din;
         r_idle_cnt  <= w_idle_nxt;
         r_wake_cnt  <= w_wake_nxt;
         r_gated_cnt <= w_gated_nxt;
      end
   end

   // Next-state and counter update logic.
   always_comb begin
      w_state_nxt = r_state;
      w_idle_nxt  = r_idle_cnt;
      w_wake_nxt  = r_wake_cnt;
      w_gated_nxt = r_gated_cnt;
      case (r_state)
         ST_ACTIVE: begin
            if (w_wake) begin
               w_idle_nxt = '0;
            end else if (r_idle_cnt == IDLE_LAST) begin
               w_state_nxt = ST_GATED;
               w_idle_nxt  = '0;
            end else begin
               w_idle_nxt = r_idle_cnt + 1'b1;
            end
         end
         ST_GATED: begin
            if (r_gated_cnt != '1) begin
               w_gated_nxt = r_gated_cnt + 1'b1;
            end
            if (w_wake) begin
               w_state_nxt = ST_WAKE;
               w_wake_nxt  = '0;
            end
         end
         ST_WAKE: begin
            // Only a data change extends the wake window; force_on does not.
            if (w_chg) begin
               w_wake_nxt = '0;
            end else if (r_wake_cnt == WAKE_LAST) begin
               w_state_nxt = ST_ACTIVE;
               w_idle_nxt  = '0;
            end else begin
               w_wake_nxt = r_wake_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_ACTIVE;
            w_idle_nxt  = '0;
            w_wake_nxt  = '0;
         end
      endcase
   end

   iiitb_cg_delay #(
      .WIDTH (WIDTH),
      .LAT   (LAT)
   ) u_delay (
      .clk (clk),
      .rst (rst),
      .i_d (din),
      .o_q (dout)
   );

   // Enable decoded directly from the state flop to stay glitch-free.
   assign cg_en     = (r_state != ST_GATED);
   assign gated_cnt = r_gated_cnt;
   assign state     = r_state;

endmodule

// File: doc/iiitb_cg_ctrl.md
# iiitb_cg_ctrl

Activity-driven clock-gate enable controller for the integrated clock-gating (ICG) datapath. It watches the incoming data word and holds the gate enable high while the data changes. After a programmable run of quiet cycles it drops the enable, and re-opens the gate on the next change. It sits directly upstream of the ICG stage: `cg_en` drives the gate's enable input, and `dout` drives the gated registers' data inputs, delayed so data arrives only when the gated clock is running.

## Interface
Parameters:
- `WIDTH`, 2: width of the monitored and forwarded data word.
- `IDLE_CYCLES`, 4: consecutive quiet cycles before gating; legal range ≥ 1.
- `LAT`, 2: data delay stages and the minimum wake duration; matches the ICG enable path of one capture flop plus one negedge latch; legal range ≥ 1.
- `CNT_W`, 16: width of the gated-cycle statistics counter.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `din`  in  WIDTH  data destined for the gated registers.
- `force_on`  in  1  level; while high, gating is inhibited.
- `cg_en`  out  1  enable to the ICG stage; 1 = clock running.
- `dout`  out  WIDTH  `din` delayed by exactly `LAT` cycles.
- `gated_cnt`  out  CNT_W  saturating count of cycles spent in GATED.
- `state`  out  2  FSM state, for debug and verification.

## Operation
- Change detect: a `din_q` register captures `din` every edge; `chg = (din != din_q)` is combinational.
- Wake request: `wake = chg | force_on`.
- FSM encoding, held in a shared package: ACTIVE=2'd0, GATED=2'd1, WAKE=2'd2. 2'd3 is illegal and recovers to ACTIVE on the next edge.
- ACTIVE:
  - `idle_cnt` clears on `wake`; otherwise it increments.
  - When `idle_cnt == IDLE_CYCLES-1` and `wake` is 0, go to GATED and clear `idle_cnt`.
- GATED:
  - `gated_cnt` increments each edge, saturating at all-ones.
  - On `wake`, go to WAKE and load `wake_cnt = 0`.
- WAKE:
  - `wake_cnt` increments each edge.
  - A `chg` in WAKE reloads `wake_cnt = 0`.
  - When `wake_cnt == LAT-1`, go to ACTIVE with `idle_cnt = 0`.
- `cg_en` is `(state != GATED)`, decoded straight from the state flop, so it is glitch-free.
- `dout` comes from a `LAT`-deep register pipeline. The pipeline is never stalled or gated.
- Reset values: state=ACTIVE, `cg_en`=1, `dout`=0, all pipeline stages 0, `din_q`=0, `idle_cnt`=0, `wake_cnt`=0, `gated_cnt`=0.

## Timing
- Gating latency: `cg_en` falls after the `IDLE_CYCLES`-th consecutive quiet edge. A change at edge e0 means GATED from edge e0+`IDLE_CYCLES`.
- Wake latency: `cg_en` rises at the first edge at which `chg` or `force_on` is sampled high in GATED.
- Alignment: `dout` shows the new word `LAT` edges after `din`. Because WAKE forces at least `LAT` enabled cycles, the gated registers always see the changed word.
- Simultaneous events:
  - `wake` on the same edge the idle count expires keeps the FSM in ACTIVE with the count cleared.
  - `force_on` rising in WAKE does not extend WAKE; only `chg` does.
- Reset mid-operation: `rst` sampled high returns every register to its reset value on that edge, regardless of state. `cg_en` is 1 in the following cycle.
- `gated_cnt` holds at 2^CNT_W−1 and never wraps. It clears only on `rst`.

## Structure
- Shared package `iiitb_cg_pkg` holds:
  - the state encodings (ST_ACTIVE, ST_GATED, ST_WAKE);
  - the default parameter constants.
- Sub-module `iiitb_cg_delay`: a parameterised `LAT`×`WIDTH` shift pipeline with synchronous reset. It also serves any other stage that must be aligned to the gate.
- Top level contains the change detector, the FSM, the idle, wake and statistics counters, and one `iiitb_cg_delay` instance.

## Test plan
Defaults for all cases: `WIDTH`=2, `IDLE_CYCLES`=4, `LAT`=2, `CNT_W`=16 unless noted.
- Reset: hold `rst` 2 cycles with `din`=2'b11 → `cg_en`=1, `dout`=0, `gated_cnt`=0, `state`=0 throughout reset and in the first cycle after.
- Idle gating: after reset, `din`=2'b01 at e0 then constant → `state`=GATED and `cg_en`=0 from e4; `gated_cnt` reads 1 at e5 and 5 at e9.
- Wake: in GATED, `din` 2'b01→2'b10 at edge w →
  - `cg_en`=1 and `state`=WAKE from w;
  - `state`=ACTIVE at w+2;
  - `dout`=2'b10 at w+2.
- Force hold: `force_on`=1 for 10 cycles with `din` constant → `cg_en` stays 1. Release `force_on` → GATED exactly 4 edges later.
- Collision: quiet count at 3 and `din` changes on the expiry edge → `state` stays ACTIVE, and the next gating comes 4 quiet edges after that change.
- Saturation and mid-operation reset, with `CNT_W`=4: hold GATED 20 cycles → `gated_cnt`=15 and no wrap. Assert `rst` while GATED → `state`=ACTIVE, `cg_en`=1, `gated_cnt`=0 on the next cycle.
